// File: rtl/rgb2luma_pkg.sv
// rgb2luma_pkg: shared constants and types for the RGB-to-luma pipeline.
//   CW_DEF / FRAC_DEF : default channel width and coefficient fraction bits
//   K0_DEF..K2_DEF    : default weights at FRAC_DEF (sum = 2^FRAC_DEF)
//   coef_set_t        : one coefficient set {k2, k1, k0}
//   side_t            : frame markers carried beside each pixel
package rgb2luma_pkg;

  localparam int unsigned CW_DEF     = 8;
  localparam int unsigned FRAC_DEF   = 8;

  // Storage width for a coefficient; supports FRAC up to 16.
  localparam int unsigned COEF_MAX_W = 17;

  localparam int unsigned K0_DEF = 76;
  localparam int unsigned K1_DEF = 150;
  localparam int unsigned K2_DEF = 30;

  // k0 occupies the low bits, matching the cfg_coef packing.
  typedef struct packed {
    logic [COEF_MAX_W-1:0] k2;
    logic [COEF_MAX_W-1:0] k1;
    logic [COEF_MAX_W-1:0] k0;
  } coef_set_t;

  typedef struct packed {
    logic sof;
    logic eol;
  } side_t;

  // Rescale an 8-fraction-bit weight to frac bits, rounding to nearest.
  function automatic logic [COEF_MAX_W-1:0] scale_coef(input int unsigned k,
                                                       input int unsigned frac);
    int unsigned v;
    if (frac >= 8) begin
      v = k << (frac - 8);
    end else begin
      v = (k + (32'd1 << (7 - frac))) >> (8 - frac);
    end
    return COEF_MAX_W'(v);
  endfunction

  function automatic coef_set_t coef_defaults(input int unsigned frac);
    coef_set_t c;
    c.k0 = scale_coef(K0_DEF, frac);
    c.k1 = scale_coef(K1_DEF, frac);
    c.k2 = scale_coef(K2_DEF, frac);
    return c;
  endfunction

endpackage

// File: rtl/luma_pipe_reg.sv
// luma_pipe_reg: one valid/ready register slice of the luma pipeline.
//   clk, reset_n         : clock, async active-low reset
//   up_valid/up_data     : beat offered by the previous stage
//   up_ready_c           : combinational ready back to the previous stage
//   dn_valid/dn_data     : registered beat presented to the next stage
//   dn_ready             : next stage accepts
module luma_pipe_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         up_valid,
  output logic         up_ready_c,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);

  // Load when empty or when the held beat leaves this cycle (bubble collapse).
  assign up_ready_c = !dn_valid || dn_ready;

  // Data only moves on a real beat so a stalled output stays stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (up_ready_c) begin
      dn_valid <= up_valid;
      if (up_valid) begin
        dn_data <= up_data;
      end
    end
  end

endmodule

// File: rtl/rgb2luma_pipe.sv
// rgb2luma_pipe: streaming RGB-to-luma converter, 3-stage stallable pipeline.
//   luma = sat((c0*k0 + c1*k1 + c2*k2 [+ 2^(FRAC-1)]) >> FRAC)
// Build option: RGB2LUMA_ROUND_EN adds the half-LSB before the shift
// (round-half-up); otherwise the result is truncated.
// Ports:
//   clk, reset_n             : clock, async active-low reset
//   in_valid/in_ready        : input handshake (in_ready combinational)
//   in_pixel                 : {c2, c1, c0}, CW bits each
//   in_sof/in_eol            : frame/line markers of the input pixel
//   cfg_we/cfg_coef          : write shadow set {k2, k1, k0}, FRAC+1 bits each
//   out_valid/out_ready      : output handshake
//   out_luma/out_sof/out_eol : registered result and its markers
module rgb2luma_pipe
  import rgb2luma_pkg::*;
#(
  parameter int unsigned CW   = CW_DEF,
  parameter int unsigned FRAC = FRAC_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3*CW-1:0]       in_pixel,
  input  logic                  in_sof,
  input  logic                  in_eol,
  input  logic                  cfg_we,
  input  logic [3*(FRAC+1)-1:0] cfg_coef,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CW-1:0]         out_luma,
  output logic                  out_sof,
  output logic                  out_eol
);

  localparam int unsigned KW     = FRAC + 1;
  localparam int unsigned PW     = CW + FRAC + 1;
  localparam int unsigned SW     = CW + FRAC + 3;
  localparam int unsigned QW     = SW - FRAC;
  localparam int unsigned SIDE_W = $bits(side_t);
  localparam int unsigned D1W    = 3 * PW + SIDE_W;
  localparam int unsigned D2W    = SW + SIDE_W;
  localparam int unsigned D3W    = CW + SIDE_W;

  localparam coef_set_t COEF_RST = coef_defaults(FRAC);

`ifdef RGB2LUMA_ROUND_EN
  localparam int unsigned RND = (FRAC > 0) ? (32'd1 << (FRAC - 1)) : 32'd0;
`endif

  coef_set_t       shadow;
  coef_set_t       active;
  coef_set_t       cfg_set;
  coef_set_t       coef_use;
  logic            sof_acc;

  side_t           in_side;
  logic [PW-1:0]   p0_c, p1_c, p2_c;
  logic [D1W-1:0]  s1_in, s1_data;
  logic            s1_valid, s2_ready;

  side_t           s1_side;
  logic [PW-1:0]   s1_p0, s1_p1, s1_p2;
  logic [SW-1:0]   sum_c;
  logic [D2W-1:0]  s2_in, s2_data;
  logic            s2_valid, s3_ready;

  side_t           s2_side;
  logic [SW-1:0]   s2_sum;
  logic [SW-1:0]   rounded_c;
  logic [QW-1:0]   shifted_c;
  logic [CW-1:0]   luma_c;
  logic [D3W-1:0]  s3_in, s3_data;

  // Unpack the configuration word into a coefficient set.
  always_comb begin
    cfg_set    = '0;
    cfg_set.k0 = COEF_MAX_W'(cfg_coef[KW-1:0]);
    cfg_set.k1 = COEF_MAX_W'(cfg_coef[2*KW-1:KW]);
    cfg_set.k2 = COEF_MAX_W'(cfg_coef[3*KW-1:2*KW]);
  end

  assign sof_acc = in_valid && in_ready && in_sof;

  // Shadow takes writes; active swaps in the pre-write shadow on an sof accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= COEF_RST;
      active <= COEF_RST;
    end else begin
      if (cfg_we) begin
        shadow <= cfg_set;
      end
      if (sof_acc) begin
        active <= shadow;
      end
    end
  end

  // S1 products; the sof beat itself already uses the set it is loading.
  always_comb begin
    coef_use = sof_acc ? shadow : active;
    p0_c     = PW'(in_pixel[CW-1:0])      * PW'(coef_use.k0);
    p1_c     = PW'(in_pixel[2*CW-1:CW])   * PW'(coef_use.k1);
    p2_c     = PW'(in_pixel[3*CW-1:2*CW]) * PW'(coef_use.k2);
    in_side  = '{sof: in_sof, eol: in_eol};
    s1_in    = {in_side, p2_c, p1_c, p0_c};
  end

  luma_pipe_reg #(.W(D1W)) u_s1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .up_valid   (in_valid),
    .up_ready_c (in_ready),
    .up_data    (s1_in),
    .dn_valid   (s1_valid),
    .dn_ready   (s2_ready),
    .dn_data    (s1_data)
  );

  // S2 sum; SW bits hold the worst-case total without overflow.
  always_comb begin
    {s1_side, s1_p2, s1_p1, s1_p0} = s1_data;
    sum_c = SW'(s1_p0) + SW'(s1_p1) + SW'(s1_p2);
    s2_in = {s1_side, sum_c};
  end

  luma_pipe_reg #(.W(D2W)) u_s2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .up_valid   (s1_valid),
    .up_ready_c (s2_ready),
    .up_data    (s2_in),
    .dn_valid   (s2_valid),
    .dn_ready   (s3_ready),
    .dn_data    (s2_data)
  );

  // S3 optional round, shift out the fraction, clamp to CW bits.
  always_comb begin
    {s2_side, s2_sum} = s2_data;
`ifdef RGB2LUMA_ROUND_EN
    rounded_c = s2_sum + SW'(RND);
`else
    rounded_c = s2_sum;
`endif
    shifted_c = QW'(rounded_c >> FRAC);
    luma_c    = (|shifted_c[QW-1:CW]) ? {CW{1'b1}} : shifted_c[CW-1:0];
    s3_in     = {s2_side, luma_c};
  end

  luma_pipe_reg #(.W(D3W)) u_s3 (
    .clk        (clk),
    .reset_n    (reset_n),
    .up_valid   (s2_valid),
    .up_ready_c (s3_ready),
    .up_data    (s3_in),
    .dn_valid   (out_valid),
    .dn_ready   (out_ready),
    .dn_data    (s3_data)
  );

  assign {out_sof, out_eol, out_luma} = s3_data;

endmodule

// File: tb/tb_rgb2luma_pipe.sv
// tb_rgb2luma_pipe: directed and random checks of rgb2luma_pipe (CW=8, FRAC=8)
// against a plain-arithmetic luma model with a beat scoreboard.
module tb_rgb2luma_pipe;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_pixel;
  logic        in_sof;
  logic        in_eol;
  logic        cfg_we;
  logic [26:0] cfg_coef;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_luma;
  logic        out_sof;
  logic        out_eol;

  rgb2luma_pipe dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .in_sof    (in_sof),
    .in_eol    (in_eol),
    .cfg_we    (cfg_we),
    .cfg_coef  (cfg_coef),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_luma  (out_luma),
    .out_sof   (out_sof),
    .out_eol   (out_eol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef RGB2LUMA_ROUND_EN
  localparam int EXP_RED100   = 30;   // 7600/256 rounded
  localparam int EXP_RED100_K = 100;  // 25500/256 rounded
  localparam int EXP_RED100_T = 4;    // 1000/256 rounded
`else
  localparam int EXP_RED100   = 29;
  localparam int EXP_RED100_K = 99;
  localparam int EXP_RED100_T = 3;
`endif

  localparam logic [23:0] WHITE  = 24'hFFFFFF;
  localparam logic [23:0] RED100 = 24'h000064;

  typedef struct {
    int luma;
    bit sof;
    bit eol;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   m_sh[3];
  int   m_ac[3];
  bit   chk_lat;
  int   emit_cnt;
  int   first_emit;
  int   last_emit;
  int   last_luma;
  bit   prev_stall;
  logic [7:0] prev_luma;
  logic prev_sof, prev_eol;

  // Luma from the weighted sum, fraction dropped (or rounded), clamped.
  function automatic int model(input logic [23:0] px, input int k0, input int k1, input int k2);
    int s;
    s = int'(px[7:0]) * k0 + int'(px[15:8]) * k1 + int'(px[23:16]) * k2;
`ifdef RGB2LUMA_ROUND_EN
    s = s + 128;
`endif
    s = s / 256;
    if (s > 255) s = 255;
    return s;
  endfunction

  // One clock: drive at negedge, observe 1 ns later, update model/scoreboard.
  task automatic step(input bit v, input logic [23:0] px, input bit sof, input bit eol,
                      input bit orr, input bit we, input logic [26:0] coef, output bit acc);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    in_pixel  = px;
    in_sof    = sof;
    in_eol    = eol;
    out_ready = orr;
    cfg_we    = we;
    cfg_coef  = coef;
    #1;
    cyc++;
    if (prev_stall) begin
      n_assert++;
      assert (out_valid === 1'b1 && out_luma === prev_luma && out_sof === prev_sof
              && out_eol === prev_eol)
      else begin
        n_fail++;
        $error("FAIL hold: observed v=%b luma=%0d sof=%b eol=%b, expected v=1 luma=%0d sof=%b eol=%b",
               out_valid, out_luma, out_sof, out_eol, prev_luma, prev_sof, prev_eol);
      end
    end
    if (out_valid && out_ready) begin
      n_assert++;
      assert (sbq.size() > 0)
      else begin
        n_fail++;
        $error("FAIL unexpected_beat: observed luma=%0d, expected no beat", out_luma);
      end
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_assert++;
        assert ({out_sof, out_eol, out_luma} === {e.sof, e.eol, 8'(e.luma)})
        else begin
          n_fail++;
          $error("FAIL beat: observed luma=%0d sof=%b eol=%b, expected luma=%0d sof=%b eol=%b",
                 out_luma, out_sof, out_eol, e.luma, e.sof, e.eol);
        end
        if (chk_lat) begin
          n_assert++;
          assert (cyc - e.cyc == 3)
          else begin
            n_fail++;
            $error("FAIL latency: observed %0d, expected 3", cyc - e.cyc);
          end
        end
      end
      last_luma = int'(out_luma);
      emit_cnt++;
      if (first_emit < 0) first_emit = cyc;
      last_emit = cyc;
    end
    prev_stall = out_valid && !out_ready;
    prev_luma  = out_luma;
    prev_sof   = out_sof;
    prev_eol   = out_eol;
    acc = v && in_ready;
    if (acc) begin
      if (sof) m_ac = m_sh;
      e.luma = model(px, m_ac[0], m_ac[1], m_ac[2]);
      e.sof  = sof;
      e.eol  = eol;
      e.cyc  = cyc;
      sbq.push_back(e);
    end
    if (we) begin
      m_sh[0] = int'(coef[8:0]);
      m_sh[1] = int'(coef[17:9]);
      m_sh[2] = int'(coef[26:18]);
    end
  endtask

  task automatic send(input logic [23:0] px, input bit sof, input bit eol);
    bit a;
    int n;
    n = 0;
    do begin
      step(1'b1, px, sof, eol, 1'b1, 1'b0, '0, a);
      n++;
    end while (!a && n < 100);
    n_assert++;
    assert (a)
    else begin
      n_fail++;
      $error("FAIL accept_timeout: observed in_ready=%b, expected accept", in_ready);
    end
  endtask

  task automatic drain();
    bit a;
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 100) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, a);
      n++;
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, a);
    n_assert++;
    assert (sbq.size() == 0)
    else begin
      n_fail++;
      $error("FAIL drain: observed %0d beats pending, expected 0", sbq.size());
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_idle(input string tag);
    n_assert++;
    assert (out_valid === 1'b0 && out_luma === 8'd0 && out_sof === 1'b0 && out_eol === 1'b0
            && in_ready === 1'b1)
    else begin
      n_fail++;
      $error("FAIL %s: observed v=%b luma=%0d sof=%b eol=%b rdy=%b, expected 0/0/0/0/1",
             tag, out_valid, out_luma, out_sof, out_eol, in_ready);
    end
  endtask

  initial begin
    bit          a;
    int          idx;
    int          n;
    int          beats;
    logic [23:0] pix[6];

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_pixel  = '0;
    in_sof    = 1'b0;
    in_eol    = 1'b0;
    cfg_we    = 1'b0;
    cfg_coef  = '0;
    out_ready = 1'b0;
    m_sh      = '{76, 150, 30};
    m_ac      = '{76, 150, 30};
    chk_lat   = 1'b0;
    emit_cnt  = 0;
    first_emit = -1;
    last_emit = 0;
    last_luma = -1;
    prev_stall = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    n_assert++;
    assert (out_valid === 1'b0)
    else begin
      n_fail++;
      $error("FAIL reset_valid: observed %b, expected 0", out_valid);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_idle("reset_state");

    // Back-to-back white: 255 each, latency 3, no gaps
    chk_lat = 1'b1;
    for (int i = 0; i < 10; i++) send(WHITE, i == 0, i == 9);
    drain();
    chk_lat = 1'b0;
    check_int("white_count", emit_cnt, 10);
    check_int("white_gapless", last_emit - first_emit, 9);
    check_int("white_luma", last_luma, 255);

    // Single red channel
    send(RED100, 1'b1, 1'b1);
    drain();
    check_int("red100_default", last_luma, EXP_RED100);

    // Mid-frame coefficient write takes effect only at the next sof
    send(RED100, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, {9'd255, 9'd255, 9'd255}, a);
    send(RED100, 1'b0, 1'b0);
    drain();
    check_int("cfg_old_weights", last_luma, EXP_RED100);
    send(WHITE, 1'b1, 1'b0);
    drain();
    check_int("cfg_new_saturate", last_luma, 255);
    send(RED100, 1'b0, 1'b1);
    drain();
    check_int("cfg_new_red", last_luma, EXP_RED100_K);
    // Write coincident with sof accept: this sof still uses the prior shadow
    step(1'b1, RED100, 1'b1, 1'b0, 1'b1, 1'b1, {9'd10, 9'd10, 9'd10}, a);
    check_int("cfg_same_cycle_acc", int'(a), 1);
    drain();
    check_int("cfg_same_cycle_old", last_luma, EXP_RED100_K);
    send(RED100, 1'b1, 1'b1);
    drain();
    check_int("cfg_same_cycle_next", last_luma, EXP_RED100_T);

    // Backpressure: 6 beats offered, out_ready low for 5 cycles
    for (int i = 0; i < 6; i++) pix[i] = 24'($urandom);
    emit_cnt = 0;
    idx = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, pix[idx], idx == 0, idx == 5, 1'b0, 1'b0, '0, a);
      if (a) idx++;
    end
    check_int("bp_absorbed", idx, 3);
    check_int("bp_in_ready", int'(in_ready), 0);
    n = 0;
    while (idx < 6 && n < 100) begin
      step(1'b1, pix[idx], idx == 0, idx == 5, 1'b1, 1'b0, '0, a);
      if (a) idx++;
      n++;
    end
    drain();
    check_int("bp_delivered", emit_cnt, 6);

    // Random traffic, backpressure and coefficient updates
    emit_cnt = 0;
    beats = 0;
    n = 0;
    while (beats < 1000 && n < 20000) begin
      step($urandom_range(0, 9) < 7, 24'($urandom), $urandom_range(0, 19) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0,
           {9'($urandom_range(0, 180)), 9'($urandom_range(0, 180)), 9'($urandom_range(0, 180))},
           a);
      if (a) beats++;
      n++;
    end
    drain();
    check_int("rand_accepted", beats, 1000);
    check_int("rand_delivered", emit_cnt, 1000);

    // Reset with beats in flight
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, {9'd200, 9'd200, 9'd200}, a);
    send(RED100, 1'b1, 1'b0);
    drain();
    for (int i = 0; i < 3; i++) step(1'b1, RED100, 1'b0, 1'b0, 1'b0, 1'b0, '0, a);
    @(posedge clk);
    #2;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    #1;
    check_idle("reset_async");
    sbq.delete();
    m_sh = '{76, 150, 30};
    m_ac = '{76, 150, 30};
    prev_stall = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_idle("reset_release");
    chk_lat = 1'b1;
    send(RED100, 1'b0, 1'b1);
    drain();
    check_int("post_reset_active", last_luma, EXP_RED100);
    send(RED100, 1'b1, 1'b1);
    drain();
    check_int("post_reset_shadow", last_luma, EXP_RED100);
    chk_lat = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
